// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU datapath types for the data-memory path
package cpu_types_pkg;

  typedef logic [31:0] word_t;
  typedef logic [29:0] waddr_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  // Link tracking works on word granularity, so byte offsets never matter.
  function automatic waddr_t wordAddr(input word_t a);
    return a[31:2];
  endfunction

endpackage

// File: rtl/link_reg.sv
// rtl/link_reg.sv - LL/SC reservation: one word address plus a valid bit
module link_reg
  import cpu_types_pkg::*;
(
  input  logic   CLK,
  input  logic   RST,
  input  logic   set,
  input  waddr_t setAddr,
  input  logic   clear,
  input  logic   wrEn,
  input  waddr_t wrAddr,
  input  logic   snoop,
  input  waddr_t snoopAddr,
  input  waddr_t queryAddr,
  output logic   valid,
  output logic   hit
);

  waddr_t linkAddr;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      valid    <= 1'b0;
      linkAddr <= '0;
    end else if (set) begin
      // A snoop to the very word being reserved wins over the new reservation.
      linkAddr <= setAddr;
      valid    <= !(snoop && (snoopAddr == setAddr));
    end else if (clear || (wrEn && (wrAddr == linkAddr)) ||
                 (snoop && (snoopAddr == linkAddr))) begin
      valid <= 1'b0;
    end
  end

  assign hit = valid && (linkAddr == queryAddr);

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - M-stage data request to RAM bridge with LL/SC support
module dmem_responder
  import cpu_types_pkg::*;
(
  input  logic      CLK,
  input  logic      RST,
  input  logic      dREN,
  input  logic      dWEN,
  input  logic      datomic,
  input  word_t     daddr,
  input  word_t     dstore,
  output logic      dhit,
  output word_t     dload,
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  input  word_t     ramload,
  input  ramstate_t ramstate,
  input  logic      snoopvalid,
  input  word_t     snoopaddr
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t state, nextState;

  logic   loadEn;
  word_t  loadVal;
  logic   linkSet;
  logic   linkClear;
  logic   linkWrEn;
  logic   linkValid;
  logic   linkHit;

  link_reg uLink (
    .CLK       (CLK),
    .RST       (RST),
    .set       (linkSet),
    .setAddr   (wordAddr(daddr)),
    .clear     (linkClear),
    .wrEn      (linkWrEn),
    .wrAddr    (wordAddr(daddr)),
    .snoop     (snoopvalid),
    .snoopAddr (wordAddr(snoopaddr)),
    .queryAddr (wordAddr(daddr)),
    .valid     (linkValid),
    .hit       (linkHit)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      dload <= '0;
    end else begin
      state <= nextState;
      if (loadEn) dload <= loadVal;
    end
  end

  always_comb begin
    nextState = state;
    loadEn    = 1'b0;
    loadVal   = '0;
    linkSet   = 1'b0;
    linkClear = 1'b0;
    linkWrEn  = 1'b0;
    ramREN    = 1'b0;
    ramWEN    = 1'b0;
    ramaddr   = '0;
    ramstore  = '0;
    dhit      = 1'b0;

    case (state)
      IDLE: begin
        if (dREN) begin
          nextState = READ;
        end else if (dWEN) begin
          if (!datomic || linkHit) begin
            nextState = WRITE;
          end else begin
            // SC without a live reservation fails without touching RAM.
            nextState = RESP;
            loadEn    = 1'b1;
            loadVal   = '0;
          end
        end
      end

      READ: begin
        if (!dREN) begin
          nextState = IDLE;
        end else begin
          ramREN  = 1'b1;
          ramaddr = daddr;
          if (ramstate == ACCESS) begin
            nextState = RESP;
            loadEn    = 1'b1;
            loadVal   = ramload;
            linkSet   = datomic;
          end
        end
      end

      WRITE: begin
        if (!dWEN) begin
          nextState = IDLE;
        end else begin
          ramWEN   = 1'b1;
          ramaddr  = daddr;
          ramstore = dstore;
          if (ramstate == ACCESS) begin
            nextState = RESP;
            loadEn    = 1'b1;
            loadVal   = {31'b0, datomic};
            linkWrEn  = 1'b1;
            linkClear = datomic && linkValid;
          end
        end
      end

      RESP: begin
        dhit      = 1'b1;
        nextState = IDLE;
      end

      default: nextState = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - randomized scoreboard bench for dmem_responder
module tb_dmem_responder;
  import cpu_types_pkg::*;

  logic      CLK = 1'b0;
  logic      RST;
  logic      dREN, dWEN, datomic;
  word_t     daddr, dstore;
  logic      dhit;
  word_t     dload;
  logic      ramREN, ramWEN;
  word_t     ramaddr, ramstore;
  word_t     ramload;
  ramstate_t ramstate;
  logic      snoopvalid;
  word_t     snoopaddr;

  always #5 CLK = ~CLK;

  dmem_responder dut (
    .CLK        (CLK),
    .RST        (RST),
    .dREN       (dREN),
    .dWEN       (dWEN),
    .datomic    (datomic),
    .daddr      (daddr),
    .dstore     (dstore),
    .dhit       (dhit),
    .dload      (dload),
    .ramREN     (ramREN),
    .ramWEN     (ramWEN),
    .ramaddr    (ramaddr),
    .ramstore   (ramstore),
    .ramload    (ramload),
    .ramstate   (ramstate),
    .snoopvalid (snoopvalid),
    .snoopaddr  (snoopaddr)
  );

  typedef struct {
    word_t load;
    int    lat;
  } exp_t;

  exp_t        expQ[$];
  int          compared = 0;
  int          mismatched = 0;
  int          cycleCount = 0;
  int          issueCycle = 0;
  int          strobeCycles = 0;
  int          dhitCount = 0;
  int          waitLeft = 0;
  word_t       ramMem[256];
  word_t       refMem[256];
  bit          refLinkValid = 1'b0;
  logic [29:0] refLink = '0;

  task automatic check(input string name, input word_t act, input word_t req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every completion pulse.
  always @(negedge CLK) begin : monitor
    exp_t e;
    cycleCount++;
    if (!RST) begin
      if (ramREN || ramWEN) strobeCycles++;
      check("strobe_exclusive", {31'b0, ramREN & ramWEN}, 32'd0);
      if (dhit) begin
        dhitCount++;
        if (expQ.size() == 0) begin
          check("unexpected_dhit", 32'd1, 32'd0);
        end else begin
          e = expQ.pop_front();
          check("dload", dload, e.load);
          check("latency", 32'(cycleCount - issueCycle), 32'(e.lat));
        end
      end
    end
  end

  // RAM model: waitLeft non-ACCESS cycles (BUSY/FREE/ERROR), then ACCESS.
  always @(negedge CLK) begin
    if (ramREN || ramWEN) begin
      if (waitLeft > 0) begin
        waitLeft--;
        case ($urandom_range(0, 2))
          0:       ramstate = BUSY;
          1:       ramstate = FREE;
          default: ramstate = ERROR;
        endcase
      end else begin
        ramstate = ACCESS;
      end
      ramload = ramMem[ramaddr[9:2]];
    end else begin
      ramstate = FREE;
      ramload  = '0;
    end
  end

  always @(posedge CLK) begin
    if (!RST && ramWEN && ramstate == ACCESS) ramMem[ramaddr[9:2]] = ramstore;
  end

  task automatic dropReq();
    dREN = 1'b0; dWEN = 1'b0; datomic = 1'b0; snoopvalid = 1'b0;
  endtask

  task automatic runTxn(input bit rd, input bit wr, input bit at, input word_t addr,
                        input word_t data, input int waits, input bit snp,
                        input word_t snpAddr);
    exp_t        e;
    int          strobesExp;
    int          s0, d0;
    bit          done;
    logic [29:0] w;
    w = addr[31:2];
    if (rd) begin
      e.load = refMem[w[7:0]];
      e.lat = 2 + waits;
      strobesExp = waits + 1;
      if (at) begin refLink = w; refLinkValid = 1'b1; end
    end else if (at && !(refLinkValid && refLink == w)) begin
      e.load = '0;
      e.lat = 1;
      strobesExp = 0;
    end else begin
      refMem[w[7:0]] = data;
      e.load = {31'b0, at};
      e.lat = 2 + waits;
      strobesExp = waits + 1;
      if (refLinkValid && (refLink == w || at)) refLinkValid = 1'b0;
    end
    if (snp && refLinkValid && refLink == snpAddr[31:2]) refLinkValid = 1'b0;

    @(negedge CLK);
    #1;
    dREN = rd; dWEN = wr; datomic = at; daddr = addr; dstore = data;
    snoopvalid = snp; snoopaddr = snpAddr;
    waitLeft = waits;
    issueCycle = cycleCount;
    s0 = strobeCycles;
    d0 = dhitCount;
    expQ.push_back(e);
    done = 1'b0;
    for (int i = 0; i < waits + 20 && !done; i++) begin
      @(negedge CLK);
      #2;
      done = dhit;
    end
    if (!done) begin
      check("dhit_timeout", 32'd0, 32'd1);
      if (expQ.size() > 0) void'(expQ.pop_back());
    end
    @(posedge CLK);
    #1;
    dropReq();
    check("strobe_cycles", 32'(strobeCycles - s0), 32'(strobesExp));
    check("dhit_count", 32'(dhitCount - d0), 32'd1);
  endtask

  task automatic snoopEvent(input word_t addr);
    @(negedge CLK);
    #1;
    snoopvalid = 1'b1; snoopaddr = addr;
    if (refLinkValid && refLink == addr[31:2]) refLinkValid = 1'b0;
    @(negedge CLK);
    #1;
    snoopvalid = 1'b0;
  endtask

  task automatic runFlush(input bit wr, input word_t addr);
    int d0;
    d0 = dhitCount;
    @(negedge CLK);
    #1;
    dREN = !wr; dWEN = wr; datomic = 1'b0; daddr = addr; dstore = $urandom;
    waitLeft = 30;
    repeat (2) @(posedge CLK);
    #1;
    dropReq();
    repeat (3) @(negedge CLK);
    #1;
    check("flush_no_dhit", 32'(dhitCount - d0), 32'd0);
  endtask

  task automatic resetMidWrite(input word_t addr);
    int d0;
    d0 = dhitCount;
    @(negedge CLK);
    #1;
    dWEN = 1'b1; datomic = 1'b0; daddr = addr; dstore = 32'hCAFEF00D;
    waitLeft = 30;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b1;
    #1;
    check("rst_ramWEN", {31'b0, ramWEN}, 32'd0);
    check("rst_ramREN", {31'b0, ramREN}, 32'd0);
    check("rst_ramaddr", ramaddr, 32'd0);
    check("rst_ramstore", ramstore, 32'd0);
    check("rst_dhit", {31'b0, dhit}, 32'd0);
    check("rst_dload", dload, 32'd0);
    refLinkValid = 1'b0;
    @(negedge CLK);
    #1;
    dropReq();
    @(negedge CLK);
    #1;
    RST = 1'b0;
    check("rst_no_dhit", 32'(dhitCount - d0), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int    op;
    word_t a;
    RST = 1'b1;
    dropReq();
    daddr = '0; dstore = '0; snoopaddr = '0;
    ramstate = FREE; ramload = '0;
    for (int i = 0; i < 256; i++) begin
      ramMem[i] = $urandom;
      refMem[i] = ramMem[i];
    end
    repeat (2) @(negedge CLK);
    check("reset_dhit", {31'b0, dhit}, 32'd0);
    check("reset_dload", dload, 32'd0);
    check("reset_ramREN", {31'b0, ramREN}, 32'd0);
    check("reset_ramWEN", {31'b0, ramWEN}, 32'd0);
    check("reset_ramaddr", ramaddr, 32'd0);
    check("reset_ramstore", ramstore, 32'd0);
    #1;
    RST = 1'b0;

    // LL then SC, then a second SC that must fail.
    ramMem[8'h40] = 32'hDEADBEEF; refMem[8'h40] = 32'hDEADBEEF;
    runTxn(1, 0, 1, 32'h100, 0, 0, 0, 0);
    runTxn(0, 1, 1, 32'h100, 32'h11112222, 0, 0, 0);
    runTxn(0, 1, 1, 32'h100, 32'h33334444, 0, 0, 0);
    // SC with no reservation.
    runTxn(0, 1, 1, 32'h200, 32'h55556666, 0, 0, 0);
    // Snoop kill with differing byte offset.
    runTxn(1, 0, 1, 32'h104, 0, 0, 0, 0);
    snoopEvent(32'h106);
    runTxn(0, 1, 1, 32'h104, 32'h77778888, 0, 0, 0);
    // Wait states on a read.
    runTxn(1, 0, 0, 32'h40, 0, 3, 0, 0);
    // Flush and reset mid-access.
    runFlush(0, 32'h44);
    runFlush(1, 32'h48);
    runTxn(1, 0, 0, 32'h48, 0, 0, 0, 0);
    resetMidWrite(32'h4C);
    runTxn(1, 0, 0, 32'h4C, 0, 1, 0, 0);
    // Plain write kills a matching reservation.
    runTxn(1, 0, 1, 32'h100, 0, 0, 0, 0);
    runTxn(0, 1, 0, 32'h100, 32'h9999AAAA, 0, 0, 0);
    runTxn(0, 1, 1, 32'h100, 32'hBBBBCCCC, 0, 0, 0);
    // Snoop coinciding with LL set, other-address snoop, byte offset ignored.
    runTxn(1, 0, 1, 32'h180, 0, 0, 1, 32'h182);
    runTxn(0, 1, 1, 32'h180, 32'h1, 0, 0, 0);
    runTxn(1, 0, 1, 32'h184, 0, 1, 1, 32'h300);
    runTxn(0, 1, 1, 32'h187, 32'h2, 2, 0, 0);
    runTxn(1, 1, 0, 32'h108, 32'hFFFF0000, 0, 0, 0);

    for (int n = 0; n < 300; n++) begin
      op = $urandom_range(0, 5);
      a = 32'h100 + ($urandom_range(0, 7) << 2) + $urandom_range(0, 3);
      case (op)
        0: runTxn(1, 0, 0, a, 0, $urandom_range(0, 3), ($urandom_range(0, 7) == 0),
                  32'h100 + ($urandom_range(0, 7) << 2));
        1: runTxn(0, 1, 0, a, $urandom, $urandom_range(0, 3), 0, 0);
        2, 3: runTxn(1, 0, 1, a, 0, $urandom_range(0, 2), ($urandom_range(0, 7) == 0),
                     32'h100 + ($urandom_range(0, 7) << 2));
        4: runTxn(0, 1, 1, a, $urandom, $urandom_range(0, 2), 0, 0);
        default: runTxn(1, 1, $urandom_range(0, 1), a, $urandom, $urandom_range(0, 1), 0, 0);
      endcase
      if ($urandom_range(0, 5) == 0) snoopEvent(32'h100 + ($urandom_range(0, 7) << 2));
      if ($urandom_range(0, 24) == 0) runFlush($urandom_range(0, 1), a);
    end

    repeat (3) @(negedge CLK);
    check("queue_drained", 32'(expQ.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-high.
REQ-002 CLK  input  1  rising-edge system clock.
REQ-003 RST  input  1  asynchronous active-high reset.
REQ-004 dREN  input  1  M-stage data read request, held until dhit.
REQ-005 dWEN  input  1  M-stage data write request, held until dhit.
REQ-006 datomic  input  1  qualifies the request as LL (with dREN) or SC (with dWEN).
REQ-007 daddr  input  32 (word_t)  byte address of the request.
REQ-008 dstore  input  32 (word_t)  store data from the EX/M latch.
REQ-009 dhit  output  1  one-cycle completion pulse; the pipeline latch advances on it.
REQ-010 dload  output  32 (word_t)  load data, or the SC result (1 = success, 0 = fail).
REQ-011 ramREN  output  1  RAM read strobe.
REQ-012 ramWEN  output  1  RAM write strobe.
REQ-013 ramaddr  output  32  RAM address.
REQ-014 ramstore  output  32  RAM write data.
REQ-015 ramload  input  32  RAM read data.
REQ-016 ramstate  input  ramstate_t  FREE/BUSY/ACCESS/ERROR.
REQ-017 snoopvalid  input  1  a write by another master is visible this cycle.
REQ-018 snoopaddr  input  32  address of the snooped write.

Function
REQ-019 States SHALL be IDLE, READ, WRITE and RESP.
REQ-020 IDLE transitions:
- dREN -> READ.
- dWEN without datomic -> WRITE.
- dWEN with datomic and a link hit -> WRITE.
- dWEN with datomic and no link hit -> RESP, with dload = 0.
REQ-021 dREN and dWEN both asserted in IDLE SHALL be serviced as a read.
REQ-022 READ SHALL drive ramREN=1 and ramaddr=daddr.
- On ACCESS: register ramload into dload and go to RESP.
- If datomic is set: also set link to daddr[31:2].
REQ-023 WRITE SHALL drive ramWEN=1, ramaddr=daddr and ramstore=dstore.
- On ACCESS: go to RESP.
- dload = 1 if SC, otherwise 0.
- Clear the link if it matches daddr[31:2] (any write) or if the write is an SC.
REQ-024 RESP SHALL assert dhit=1 for exactly one cycle, then go to IDLE; dhit=0 in every other state.
REQ-025 ramstate BUSY/FREE in READ/WRITE SHALL hold the state and strobes; ERROR SHALL retry (strobes stay asserted).
REQ-026 If the request drops (flush) in READ/WRITE, the block SHALL return to IDLE next cycle with no dhit and no link change.
REQ-027 Latency:
- Zero-wait RAM: dhit two cycles after the request is first seen in IDLE.
- Failed SC: dhit one cycle after the request is first seen in IDLE.
REQ-028 A link hit SHALL mean link valid and linkaddr == daddr[31:2]; byte offset bits [1:0] SHALL be ignored.
REQ-029 snoopvalid with snoopaddr[31:2] == linkaddr SHALL clear link valid in any state.
REQ-030 A snoop clear and an LL set to the same address in the same cycle SHALL leave the link invalid.
REQ-031 A new LL SHALL overwrite any existing link.
REQ-032 ramREN/ramWEN SHALL never both be 1, and SHALL both be 0 in IDLE and RESP.

Reset
REQ-033 RST SHALL asynchronously force the following, regardless of current state:
- state IDLE, dhit 0, dload 0.
- link valid 0, linkaddr 0.
- ramREN/ramWEN 0, ramaddr/ramstore 0.
REQ-034 Reset mid-READ/WRITE SHALL abandon the access with no dhit.

Structure
REQ-035 word_t and ramstate_t SHALL come from cpu_types_pkg; the FSM state enum SHALL be local to the module.
REQ-036 Link tracking SHALL be a sub-module, link_reg.
- Inputs: set, setaddr, clear-on-match write, snoop.
- Outputs: valid, hit.

Verification
REQ-037 LL then SC: dREN+datomic @0x100, ramload 0xDEADBEEF -> dload=0xDEADBEEF with dhit; dWEN+datomic @0x100 -> ramWEN, dload=1, link cleared.
REQ-038 SC with no link: dWEN+datomic @0x200 -> no ramWEN, dhit next cycle, dload=0.
REQ-039 Snoop kill: LL @0x104, then snoopvalid @0x106 -> SC @0x104 returns dload=0 with no RAM write.
REQ-040 Wait states: ramstate BUSY for 3 cycles then ACCESS on a read @0x40 -> ramREN held 4 cycles, dhit exactly once, in the cycle after ACCESS.
REQ-041 Flush/reset: dREN drops while READ is BUSY -> IDLE, no dhit; RST asserted mid-WRITE -> all outputs 0 immediately.
REQ-042 Plain write @0x100 after LL @0x100 -> link cleared; a following SC returns 0.
